// File: rtl/rv_dmem_pkg.sv
// rtl/rv_dmem_pkg.sv - FSM encodings, funct3 constants and size helper for the data-memory sequencer
package rv_dmem_pkg;

  localparam int DMEM_ADDR_W = 12;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } dmem_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // Low address bits that must be zero for a naturally aligned access of this size.
  function automatic logic [2:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   size_mask = 3'b000;
      2'b01:   size_mask = 3'b001;
      2'b10:   size_mask = 3'b011;
      default: size_mask = 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/rv_dmem_align.sv
// rtl/rv_dmem_align.sv - lane extraction/extension, store merge and alignment check (combinational)
module rv_dmem_align
  import rv_dmem_pkg::*;
(
  input  logic [63:0] word,
  input  logic [63:0] wdata,
  input  logic [2:0]  off,
  input  logic [2:0]  funct3,
  input  logic [2:0]  chk_off,
  input  logic [1:0]  chk_size,
  output logic [63:0] load_data,
  output logic [63:0] merge_data,
  output logic        misalign
);

  logic [5:0]  sh;
  logic [63:0] lane;
  logic [63:0] mask;

  assign sh   = {off, 3'b000};
  assign lane = word >> sh;

  always_comb begin
    load_data = '0;
    case (funct3)
      F3_B:    load_data = {{56{lane[7]}}, lane[7:0]};
      F3_BU:   load_data = {56'd0, lane[7:0]};
      F3_H:    load_data = {{48{lane[15]}}, lane[15:0]};
      F3_HU:   load_data = {48'd0, lane[15:0]};
      F3_W:    load_data = {{32{lane[31]}}, lane[31:0]};
      F3_WU:   load_data = {32'd0, lane[31:0]};
      F3_D:    load_data = lane;
      default: load_data = '0;
    endcase
  end

  always_comb begin
    mask = '0;
    case (funct3[1:0])
      2'b00:   mask = 64'h0000_0000_0000_00ff;
      2'b01:   mask = 64'h0000_0000_0000_ffff;
      2'b10:   mask = 64'h0000_0000_ffff_ffff;
      default: mask = 64'hffff_ffff_ffff_ffff;
    endcase
  end

  assign merge_data = (word & ~(mask << sh)) | ((wdata & mask) << sh);
  assign misalign   = |(chk_off & size_mask(chk_size));

endmodule

// File: rtl/rv_dmem_ctrl.sv
// rtl/rv_dmem_ctrl.sv - RV64 load/store sequencer with read-modify-write in front of rv_data_mem
// DMEM_MISALIGN_CHK_EN: misaligned accesses return an error; otherwise they are forced to natural alignment.
module rv_dmem_ctrl
  import rv_dmem_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int XLEN   = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [2:0]      req_funct3_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] resp_rdata_o,
  output logic            resp_err_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic            mem_wr_en_o,
  output logic [XLEN-1:0] mem_wr_data_o,
  output logic            mem_rd_en_o,
  input  logic [XLEN-1:0] mem_rd_data_i,
  output logic            busy_o
);

  dmem_state_t state_q, state_d;

  logic [XLEN-1:0] addr_q, wbuf_q, rdata_q;
  logic [2:0]      f3_q;
  logic            we_q, err_q;

  logic            accept, illegal, misalign, req_err;
  logic [XLEN-1:0] addr_lat, mem_idx;
  logic [63:0]     load_data, merge_data;

  assign accept  = req_valid_i && req_ready_o;
  assign illegal = req_we_i ? req_funct3_i[2] : (req_funct3_i == 3'b111);

`ifdef DMEM_MISALIGN_CHK_EN
  assign req_err  = illegal | misalign;
  assign addr_lat = req_addr_i;
`else
  assign req_err  = illegal;
  assign addr_lat = misalign ? {req_addr_i[XLEN-1:3], req_addr_i[2:0] & ~size_mask(req_funct3_i[1:0])}
                             : req_addr_i;
`endif

  rv_dmem_align u_align (
    .word       (mem_rd_data_i),
    .wdata      (wbuf_q),
    .off        (addr_q[2:0]),
    .funct3     (f3_q),
    .chk_off    (req_addr_i[2:0]),
    .chk_size   (req_funct3_i[1:0]),
    .load_data  (load_data),
    .merge_data (merge_data),
    .misalign   (misalign)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          if (req_err)                                 state_d = ST_RESP;
          else if (req_we_i && req_funct3_i == F3_D)   state_d = ST_WRITE;
          else                                         state_d = ST_READ;
        end
      end
      ST_READ:  state_d = ST_WAIT;
      ST_WAIT:  state_d = we_q ? ST_WRITE : ST_RESP;
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  if (resp_ready_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // wbuf_q carries the raw store data until WAIT, then the merged doubleword for WRITE.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wbuf_q  <= '0;
      rdata_q <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else if (accept) begin
      addr_q  <= addr_lat;
      wbuf_q  <= req_wdata_i;
      rdata_q <= '0;
      f3_q    <= req_funct3_i;
      we_q    <= req_we_i;
      err_q   <= req_err;
    end else if (state_q == ST_WAIT) begin
      if (we_q) wbuf_q  <= merge_data;
      else      rdata_q <= load_data;
    end
  end

  assign req_ready_o  = (state_q == ST_IDLE);
  assign busy_o       = (state_q != ST_IDLE);
  assign mem_rd_en_o  = (state_q == ST_READ);
  assign mem_wr_en_o  = (state_q == ST_WRITE);
  assign resp_valid_o = (state_q == ST_RESP);

  // Upper index bits pass straight through; the memory only decodes the low ADDR_W.
  assign mem_idx       = {3'b000, addr_q[XLEN-1:ADDR_W+3], addr_q[ADDR_W+2:3]};
  assign mem_addr_o    = (mem_rd_en_o || mem_wr_en_o) ? mem_idx : '0;
  assign mem_wr_data_o = mem_wr_en_o ? wbuf_q : '0;
  assign resp_rdata_o  = resp_valid_o ? rdata_q : '0;
  assign resp_err_o    = resp_valid_o && err_q;

endmodule

// File: tb/tb_rv_dmem_ctrl.sv
// tb/tb_rv_dmem_ctrl.sv - self-checking bench for rv_dmem_ctrl against a byte-level reference memory
module tb_rv_dmem_ctrl;

  localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, D = 3'b011;
  localparam logic [2:0] BU = 3'b100, HU = 3'b101, WU = 3'b110;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i, req_ready_o, req_we_i;
  logic [2:0]  req_funct3_i;
  logic [63:0] req_addr_i, req_wdata_i;
  logic        resp_valid_o, resp_ready_i, resp_err_o;
  logic [63:0] resp_rdata_o, mem_addr_o, mem_wr_data_o, mem_rd_data_i;
  logic        mem_wr_en_o, mem_rd_en_o, busy_o;

  int n_assert = 0;
  int n_fail   = 0;
  int n_rd = 0, n_wr = 0, n_ovl = 0, n_leak = 0;
  logic [63:0] last_rd_addr = '0, last_wr_addr = '0;

  logic [63:0] mem [0:4095];
  logic [63:0] rd_q;
  logic [7:0]  ref_b [0:32767];

  always #5 clk = ~clk;

  rv_dmem_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_we_i      (req_we_i),
    .req_funct3_i  (req_funct3_i),
    .req_addr_i    (req_addr_i),
    .req_wdata_i   (req_wdata_i),
    .resp_valid_o  (resp_valid_o),
    .resp_ready_i  (resp_ready_i),
    .resp_rdata_o  (resp_rdata_o),
    .resp_err_o    (resp_err_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wr_en_o   (mem_wr_en_o),
    .mem_wr_data_o (mem_wr_data_o),
    .mem_rd_en_o   (mem_rd_en_o),
    .mem_rd_data_i (mem_rd_data_i),
    .busy_o        (busy_o)
  );

  // Data memory: 4096 x 64, registered read, index truncated to 12 bits.
  always @(posedge clk) begin
    if (mem_wr_en_o) mem[mem_addr_o[11:0]] <= mem_wr_data_o;
    if (mem_rd_en_o) rd_q <= mem[mem_addr_o[11:0]];
  end
  assign mem_rd_data_i = rd_q;

  always @(negedge clk) begin
    if (mem_rd_en_o) begin n_rd <= n_rd + 1; last_rd_addr <= mem_addr_o; end
    if (mem_wr_en_o) begin n_wr <= n_wr + 1; last_wr_addr <= mem_addr_o; end
    if (mem_rd_en_o && mem_wr_en_o) n_ovl <= n_ovl + 1;
    if ((!mem_rd_en_o && !mem_wr_en_o && mem_addr_o != 0) || (!mem_wr_en_o && mem_wr_data_o != 0))
      n_leak <= n_leak + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_word(input int idx);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = ref_b[idx*8 + i];
    return r;
  endfunction

  // Reference: size/sign rules applied to a flat byte array, 32 KiB wrap.
  task automatic model(input logic we, input logic [2:0] f3, input logic [63:0] addr, input logic [63:0] wdata,
                       output logic [63:0] e_rdata, output logic e_err, output int e_lat,
                       output int e_rd, output int e_wr, output logic [63:0] e_idx);
    int          size;
    logic        ill, mis;
    logic [63:0] ea, v;
    ill  = we ? f3[2] : (f3 == 3'b111);
    size = 1 << f3[1:0];
    mis  = (addr % 64'(size)) != 0;
`ifdef DMEM_MISALIGN_CHK_EN
    e_err = ill | mis;
`else
    e_err = ill;
`endif
    ea      = addr - (addr % 64'(size));
    e_idx   = ea / 64'd8;
    e_rdata = '0;
    e_rd    = 0;
    e_wr    = 0;
    if (e_err) begin
      e_lat = 1;
    end else if (we) begin
      for (int i = 0; i < size; i++) ref_b[int'((ea + 64'(i)) % 64'd32768)] = 8'(wdata >> (8*i));
      e_wr  = 1;
      e_rd  = (size < 8) ? 1 : 0;
      e_lat = (size == 8) ? 2 : 4;
    end else begin
      v = '0;
      for (int i = 0; i < size; i++) v = v | (64'(ref_b[int'((ea + 64'(i)) % 64'd32768)]) << (8*i));
      if (!f3[2] && size < 8 && v[8*size-1]) v = v | ~((64'd1 << (8*size)) - 64'd1);
      e_rdata = v;
      e_rd    = 1;
      e_lat   = 3;
    end
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid_o && lat < 12);
  endtask

  task automatic run_txn(input string name, input logic we, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] wdata, output logic [63:0] obs, output logic obs_err);
    logic [63:0] e_rdata, e_idx;
    logic        e_err;
    int          e_lat, e_rd, e_wr, lat, rd0, wr0, ov0, lk0;
    model(we, f3, addr, wdata, e_rdata, e_err, e_lat, e_rd, e_wr, e_idx);
    rd0 = n_rd; wr0 = n_wr; ov0 = n_ovl; lk0 = n_leak;
    @(negedge clk);
    check({name, " req_ready"}, 64'(req_ready_o), 64'd1);
    req_valid_i = 1'b1; req_we_i = we; req_funct3_i = f3; req_addr_i = addr; req_wdata_i = wdata;
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    wait_resp(lat);
    check({name, " latency"}, 64'(lat), 64'(e_lat));
    obs     = resp_rdata_o;
    obs_err = resp_err_o;
    check({name, " rdata"}, obs, e_rdata);
    check({name, " err"}, 64'(obs_err), 64'(e_err));
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      check({name, " held"}, resp_rdata_o, obs);
    end
    resp_ready_i = 1'b1;
    @(posedge clk);
    #1 resp_ready_i = 1'b0;
    check({name, " rd strobes"}, 64'(n_rd - rd0), 64'(e_rd));
    check({name, " wr strobes"}, 64'(n_wr - wr0), 64'(e_wr));
    check({name, " strobe overlap/leak"}, 64'((n_ovl - ov0) + (n_leak - lk0)), 64'd0);
    if (e_rd != 0) check({name, " rd addr"}, last_rd_addr, e_idx);
    if (e_wr != 0) begin
      check({name, " wr addr"}, last_wr_addr, e_idx);
      check({name, " mem word"}, mem[e_idx[11:0]], ref_word(int'(e_idx[11:0])));
    end
  endtask

  initial begin
    logic [63:0] obs, e1, e2, eidx, addr, saved;
    logic        oerr, eerr;
    int          elat, erd, ewr, lat, wr0;

    for (int i = 0; i < 32768; i++) ref_b[i] = 8'h00;
    rst = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0; req_funct3_i = '0;
    req_addr_i = '0; req_wdata_i = '0; resp_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset req_ready", 64'(req_ready_o), 64'd1);
    check("reset outputs", {resp_valid_o, resp_err_o, mem_wr_en_o, mem_rd_en_o, busy_o}, 64'd0);
    check("reset data buses", resp_rdata_o | mem_addr_o | mem_wr_data_o, 64'd0);
    rst = 1'b0;

    run_txn("sd40", 1'b1, D, 64'h40, 64'h1122334455667788, obs, oerr);
    check("sd40 index", last_wr_addr, 64'h8);
    run_txn("ld40", 1'b0, D, 64'h40, 64'h0, obs, oerr);
    check("ld40 value", obs, 64'h1122334455667788);
    run_txn("sb43", 1'b1, B, 64'h43, 64'hAB, obs, oerr);
    check("sb43 merged", mem[8], 64'h11223344AB667788);

    run_txn("sd40 pattern", 1'b1, D, 64'h40, 64'h80FF00007FFF8001, obs, oerr);
    run_txn("lb40", 1'b0, B, 64'h40, 64'h0, obs, oerr);
    check("lb40 value", obs, 64'h0000000000000001);
    run_txn("lh46", 1'b0, H, 64'h46, 64'h0, obs, oerr);
    check("lh46 value", obs, 64'hFFFFFFFFFFFF80FF);
    run_txn("lhu46", 1'b0, HU, 64'h46, 64'h0, obs, oerr);
    check("lhu46 value", obs, 64'h00000000000080FF);
    run_txn("lw44", 1'b0, W, 64'h44, 64'h0, obs, oerr);
    check("lw44 value", obs, 64'hFFFFFFFF80FF0000);
    run_txn("lwu44", 1'b0, WU, 64'h44, 64'h0, obs, oerr);
    check("lwu44 value", obs, 64'h0000000080FF0000);

    run_txn("lw42", 1'b0, W, 64'h42, 64'h0, obs, oerr);
`ifdef DMEM_MISALIGN_CHK_EN
    check("lw42 err const", {63'd0, oerr}, 64'd1);
    check("lw42 rdata const", obs, 64'd0);
`else
    check("lw42 err const", {63'd0, oerr}, 64'd0);
    check("lw42 rdata const", obs, 64'h000000007FFF8001);
`endif
    run_txn("ld f3=111", 1'b0, 3'b111, 64'h40, 64'h0, obs, oerr);
    check("ld f3=111 err const", {63'd0, oerr}, 64'd1);
    run_txn("st f3=100", 1'b1, 3'b100, 64'h40, 64'hDEAD, obs, oerr);
    check("st f3=100 word kept", mem[8], 64'h80FF00007FFF8001);
    run_txn("ld wrap 0x8040", 1'b0, D, 64'h8040, 64'h0, obs, oerr);
    check("ld wrap value", obs, 64'h80FF00007FFF8001);

    // Backpressure: response held for 5 cycles while a second request waits.
    model(1'b0, D, 64'h40, 64'h0, e1, eerr, elat, erd, ewr, eidx);
    model(1'b0, BU, 64'h41, 64'h0, e2, eerr, elat, erd, ewr, eidx);
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_funct3_i = D; req_addr_i = 64'h40;
    @(posedge clk);
    #1 req_funct3_i = BU; req_addr_i = 64'h41;
    wait_resp(lat);
    check("bp first latency", 64'(lat), 64'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp resp_valid held", 64'(resp_valid_o), 64'd1);
      check("bp rdata held", resp_rdata_o, e1);
      check("bp req_ready low", 64'(req_ready_o), 64'd0);
    end
    resp_ready_i = 1'b1;
    @(posedge clk);
    #1 resp_ready_i = 1'b0;
    @(negedge clk);
    check("bp idle after release", {62'd0, req_ready_o, busy_o}, 64'b10);
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    wait_resp(lat);
    check("bp second latency", 64'(lat), 64'd3);
    check("bp second rdata", resp_rdata_o, e2);
    resp_ready_i = 1'b1;
    @(posedge clk);
    #1 resp_ready_i = 1'b0;

    // Reset while an SH sits in WAIT: the write must never happen.
    saved = mem[8];
    wr0   = n_wr;
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = 1'b1; req_funct3_i = H; req_addr_i = 64'h40; req_wdata_i = 64'hBEEF;
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    @(negedge clk);
    check("rmw read strobe", 64'(mem_rd_en_o), 64'd1);
    @(negedge clk);
    check("rmw in wait", {62'd0, busy_o, mem_rd_en_o}, 64'b10);
    rst = 1'b1;
    @(negedge clk);
    check("rmw reset outputs", {resp_valid_o, resp_err_o, mem_wr_en_o, mem_rd_en_o, busy_o, !req_ready_o}, 64'd0);
    check("rmw reset buses", resp_rdata_o | mem_addr_o | mem_wr_data_o, 64'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rmw no write", 64'(n_wr - wr0), 64'd0);
    check("rmw word unchanged", mem[8], saved);

    // Random traffic over a preloaded window, with random upper address bits.
    for (int i = 0; i < 8; i++)
      run_txn("preload", 1'b1, D, 64'h100 + 64'(8*i), {$urandom, $urandom}, obs, oerr);
    for (int i = 0; i < 80; i++) begin
      addr        = {$urandom, $urandom};
      addr[14:0]  = 15'h100 + 15'($urandom_range(0, 63));
      run_txn("random", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), addr, {$urandom, $urandom}, obs, oerr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
